// File: rtl/pkg_sfrs_definition.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pkg_sfrs_definition                                              |
// | Brief   : Shared SFR-side types for the multi-channel PWM peripheral.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pkg_sfrs_definition;

  localparam int unsigned c_PWM_MC_MAX_CH = 8;

  typedef enum logic [1:0] {
    PWM_MC_OFF  = 2'd0,
    PWM_MC_UP   = 2'd1,
    PWM_MC_DOWN = 2'd2
  } pwm_mc_state_e;

  localparam logic [1:0] c_ST_OFF  = PWM_MC_OFF;
  localparam logic [1:0] c_ST_UP   = PWM_MC_UP;
  localparam logic [1:0] c_ST_DOWN = PWM_MC_DOWN;

  // Sized for the largest channel count; narrower instances use the low bits.
  typedef struct packed {
    logic                       on;
    logic                       soft_rst;
    logic                       ld;
    logic                       center;
    logic [c_PWM_MC_MAX_CH-1:0] pol;
    logic [c_PWM_MC_MAX_CH-1:0] oen;
    logic                       ld_busy;
    logic                       prm_p;
  } pwm_mc_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pwm_mc_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_mc_cmp                                                        |
// | Brief  : One PWM channel: active duty/phase, compare, output and dcm pulse. |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_mc_cmp
  import pkg_sfrs_definition::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_dc_sh,
  input  logic [CNT_W-1:0] i_ph_sh,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_pr,
  input  logic             i_run,
  input  logic             i_ctr,
  input  logic             i_down,
  input  logic             i_pol,
  input  logic             i_oen,
  output logic             o_pwm,
  output logic             o_dcm
);

  localparam logic [CNT_W:0] c_ONE_W1 = {{CNT_W{1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_dc_q, r_ph_q;
  logic [CNT_W-1:0] w_dc_d, w_ph_d;
  logic             r_act_q, r_pwm_q, r_dcm_q;
  logic             w_act_d, w_pwm_d, w_dcm_d;
  logic [CNT_W:0]   w_pr1, w_phm, w_raw, w_pos;
  logic             w_edge_act, w_ctr_act;

  // Position inside the period relative to the phase offset, kept in CNT_W+1 bits.
  always_comb begin
    w_pr1      = {1'b0, i_pr} + c_ONE_W1;
    w_phm      = {1'b0, r_ph_q} % w_pr1;
    w_raw      = {1'b0, i_cnt} + w_pr1 - w_phm;
    w_pos      = (w_raw >= w_pr1) ? (w_raw - w_pr1) : w_raw;
    w_edge_act = (w_pos < {1'b0, r_dc_q});
    w_ctr_act  = i_down ? (i_cnt <= r_dc_q) : (i_cnt < r_dc_q);
    w_act_d    = i_run & (i_ctr ? w_ctr_act : w_edge_act);
    w_pwm_d    = i_oen ? (w_act_d ^ i_pol) : i_pol;
    w_dcm_d    = r_act_q & ~w_act_d;
    w_dc_d     = i_load ? i_dc_sh : r_dc_q;
    w_ph_d     = i_load ? i_ph_sh : r_ph_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dc_q  <= '0;
      r_ph_q  <= '0;
      r_act_q <= 1'b0;
      r_pwm_q <= 1'b0;
      r_dcm_q <= 1'b0;
    end else begin
      r_dc_q  <= w_dc_d;
      r_ph_q  <= w_ph_d;
      r_act_q <= w_act_d;
      r_pwm_q <= w_pwm_d;
      r_dcm_q <= w_dcm_d;
    end
  end

  assign o_pwm = r_pwm_q;
  assign o_dcm = r_dcm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_multichannel                                                  |
// | Brief  : Shared timebase, OFF/UP/DOWN FSM and shadow load for CH_NUM PWMs. |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_multichannel
  import pkg_sfrs_definition::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cnt_tick,
  input  logic                    on,
  input  logic                    soft_rst,
  input  logic                    ld,
  input  logic                    center,
  input  logic [CNT_W-1:0]        pr_sh,
  input  logic [CH_NUM*CNT_W-1:0] dc_sh,
  input  logic [CH_NUM*CNT_W-1:0] ph_sh,
  input  logic [CH_NUM-1:0]       pol,
  input  logic [CH_NUM-1:0]       oen,
  output logic [CH_NUM-1:0]       pwm_o,
  output logic [CNT_W-1:0]        tmr_val,
  output logic                    ld_busy,
  output logic                    prm_p,
  output logic [CH_NUM-1:0]       dcm_p
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state_q, w_state_d;
  logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
  logic [CNT_W-1:0] r_pr_q, w_pr_d;
  logic             r_ctr_q, w_ctr_d;
  logic             r_ld_busy_q, w_busy_d;
  logic             r_prm_q, w_prm_d;
  logic             w_load, w_wrap, w_off, w_ctr_eff, w_run;

  assign w_off     = (r_state_q == c_ST_OFF);
  assign w_run     = ~w_off & on;
  // Center mode with a zero period degenerates to the edge-mode wrap.
  assign w_ctr_eff = r_ctr_q & (r_pr_q != '0);

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_pr_d    = r_pr_q;
    w_ctr_d   = r_ctr_q;
    w_busy_d  = r_ld_busy_q | ld;
    w_prm_d   = 1'b0;
    w_load    = 1'b0;
    w_wrap    = 1'b0;
    if (!on) begin
      w_state_d = c_ST_OFF;
      w_cnt_d   = '0;
      if (w_off) begin
        w_ctr_d = center;
        w_load  = w_busy_d;
      end
    end else if (w_off) begin
      w_state_d = c_ST_UP;
      w_cnt_d   = '0;
      w_ctr_d   = center;
      w_load    = w_busy_d;
    end else if (soft_rst) begin
      w_state_d = c_ST_UP;
      w_cnt_d   = '0;
    end else if (cnt_tick) begin
      if (!w_ctr_eff) begin
        if (r_cnt_q >= r_pr_q) w_wrap = 1'b1;
        else                   w_cnt_d = r_cnt_q + c_CNT_ONE;
      end else if (r_state_q == c_ST_UP) begin
        if (r_cnt_q >= r_pr_q - c_CNT_ONE) begin
          w_state_d = c_ST_DOWN;
          w_cnt_d   = r_pr_q;
        end else begin
          w_cnt_d = r_cnt_q + c_CNT_ONE;
        end
      end else begin
        if (r_cnt_q <= c_CNT_ONE) w_wrap = 1'b1;
        else                      w_cnt_d = r_cnt_q - c_CNT_ONE;
      end
      if (w_wrap) begin
        w_state_d = c_ST_UP;
        w_cnt_d   = '0;
        w_prm_d   = 1'b1;
        w_ctr_d   = center;
        w_load    = w_busy_d;
      end
    end
    if (w_load) begin
      w_pr_d   = pr_sh;
      w_busy_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state_q   <= c_ST_OFF;
      r_cnt_q     <= '0;
      r_pr_q      <= '0;
      r_ctr_q     <= 1'b0;
      r_ld_busy_q <= 1'b0;
      r_prm_q     <= 1'b0;
    end else begin
      r_state_q   <= w_state_d;
      r_cnt_q     <= w_cnt_d;
      r_pr_q      <= w_pr_d;
      r_ctr_q     <= w_ctr_d;
      r_ld_busy_q <= w_busy_d;
      r_prm_q     <= w_prm_d;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_mc_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .i_load  (w_load),
      .i_dc_sh (dc_sh[i*CNT_W +: CNT_W]),
      .i_ph_sh (ph_sh[i*CNT_W +: CNT_W]),
      .i_cnt   (r_cnt_q),
      .i_pr    (r_pr_q),
      .i_run   (w_run),
      .i_ctr   (w_ctr_eff),
      .i_down  (r_state_q == c_ST_DOWN),
      .i_pol   (pol[i]),
      .i_oen   (oen[i]),
      .o_pwm   (pwm_o[i]),
      .o_dcm   (dcm_p[i])
    );
  end

  assign tmr_val = r_cnt_q;
  assign ld_busy = r_ld_busy_q;
  assign prm_p   = r_prm_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pwm_multichannel                                               |
// | Brief  : Directed + random stimulus against a period-position model.       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_multichannel;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst, cnt_tick, on, soft_rst, ld, center;
  logic [W-1:0]  pr_sh;
  logic [CH*W-1:0] dc_sh, ph_sh;
  logic [CH-1:0] pol, oen;
  logic [CH-1:0] pwm_o, dcm_p;
  logic [W-1:0]  tmr_val;
  logic          ld_busy, prm_p;

  always #5 sys_clk = ~sys_clk;

  pwm_multichannel #(.CH_NUM(CH), .CNT_W(W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cnt_tick (cnt_tick),
    .on       (on),
    .soft_rst (soft_rst),
    .ld       (ld),
    .center   (center),
    .pr_sh    (pr_sh),
    .dc_sh    (dc_sh),
    .ph_sh    (ph_sh),
    .pol      (pol),
    .oen      (oen),
    .pwm_o    (pwm_o),
    .tmr_val  (tmr_val),
    .ld_busy  (ld_busy),
    .prm_p    (prm_p),
    .dcm_p    (dcm_p)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: m_p is the tick position inside the current period.
  int      m_run = 0, m_p = 0, m_pr = 0, m_ctr = 0, m_busy = 0, m_prm = 0;
  int      m_dc[CH];
  int      m_ph[CH];
  bit [CH-1:0] e_act = '0, e_out = '0, e_dcm = '0;

  function automatic bit ctr_eff();
    return (m_ctr != 0) && (m_pr != 0);
  endfunction

  function automatic int m_cnt();
    if (ctr_eff() && m_p >= m_pr) return 2 * m_pr - m_p;
    return m_p;
  endfunction

  function automatic bit m_active(int i);
    int c   = m_cnt();
    int per = m_pr + 1;
    int off;
    if (ctr_eff()) return (m_p < m_pr) ? (c < m_dc[i]) : (c <= m_dc[i]);
    off = (c - (m_ph[i] % per) + per) % per;
    return off < m_dc[i];
  endfunction

  task automatic load_cfg();
    m_pr = int'(pr_sh);
    for (int i = 0; i < CH; i++) begin
      m_dc[i] = int'(dc_sh[i*W +: W]);
      m_ph[i] = int'(ph_sh[i*W +: W]);
    end
  endtask

  task automatic model_edge();
    bit [CH-1:0] na;
    int          per;
    bit          ldreq;
    if (sys_rst) begin
      m_run = 0; m_p = 0; m_pr = 0; m_ctr = 0; m_busy = 0; m_prm = 0;
      for (int i = 0; i < CH; i++) begin
        m_dc[i] = 0;
        m_ph[i] = 0;
      end
      e_act = '0; e_out = '0; e_dcm = '0;
      return;
    end
    for (int i = 0; i < CH; i++) na[i] = (m_run != 0 && on) ? m_active(i) : 1'b0;
    e_dcm = e_act & ~na;
    e_act = na;
    for (int i = 0; i < CH; i++) e_out[i] = oen[i] ? (na[i] ^ pol[i]) : pol[i];
    ldreq = (m_busy != 0) || ld;
    m_prm = 0;
    if (!on) begin
      if (m_run == 0) begin
        m_ctr = int'(center);
        if (ldreq) load_cfg();
        m_busy = 0;
      end else begin
        m_busy = int'(ldreq);
      end
      m_run = 0;
      m_p   = 0;
    end else if (m_run == 0) begin
      m_run = 1;
      m_p   = 0;
      m_ctr = int'(center);
      if (ldreq) load_cfg();
      m_busy = 0;
    end else if (soft_rst) begin
      m_p    = 0;
      m_busy = int'(ldreq);
    end else if (cnt_tick) begin
      per = ctr_eff() ? 2 * m_pr : m_pr + 1;
      if (m_p + 1 >= per) begin
        m_p   = 0;
        m_prm = 1;
        m_ctr = int'(center);
        if (ldreq) load_cfg();
        m_busy = 0;
      end else begin
        m_p    = m_p + 1;
        m_busy = int'(ldreq);
      end
    end else begin
      m_busy = int'(ldreq);
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("tmr_val", 32'(tmr_val), 32'(m_cnt()));
    chk("prm_p",   32'(prm_p),   32'(m_prm));
    chk("ld_busy", 32'(ld_busy), 32'(m_busy));
    chk("pwm_o",   32'(pwm_o),   32'(e_out));
    chk("dcm_p",   32'(dcm_p),   32'(e_dcm));
    ld       = 1'b0;
    soft_rst = 1'b0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_dc[i] = 0;
      m_ph[i] = 0;
    end
    sys_rst = 1'b1; cnt_tick = 1'b0; on = 1'b0; soft_rst = 1'b0; ld = 1'b0;
    center = 1'b0; pr_sh = '0; dc_sh = '0; ph_sh = '0; pol = '0; oen = '0;
    run(2);
    sys_rst = 1'b0;

    // Edge mode PR=9: DC 3, 0 (never), 10 (always), 7 with phase 2
    pr_sh = 8'd9;
    dc_sh = {8'd7, 8'd10, 8'd0, 8'd3};
    ph_sh = {8'd2, 8'd0, 8'd0, 8'd0};
    oen   = 4'hF;
    ld = 1'b1; step();
    on = 1'b1; cnt_tick = 1'b1;
    run(25);

    // Phase 8 and 4, one inverted channel, one phase beyond the period
    dc_sh = {8'd3, 8'd3, 8'd3, 8'd3};
    ph_sh = {8'd23, 8'd0, 8'd4, 8'd8};
    pol   = 4'b0100;
    ld = 1'b1; step();
    run(24);
    for (int k = 0; k < 30; k++) begin
      cnt_tick = 1'($urandom_range(0, 1));
      step();
    end
    cnt_tick = 1'b1;

    // Center mode PR=4: DC 2, 4 (always), 0 (never), 3
    center = 1'b1; pr_sh = 8'd4; pol = '0;
    dc_sh  = {8'd3, 8'd0, 8'd4, 8'd2};
    ld = 1'b1; step();
    run(24);

    // Back to edge PR=9, then shadow load PR=4 DC=1 at cnt 3
    center = 1'b0; pr_sh = 8'd9; dc_sh = {4{8'd5}}; ph_sh = '0;
    ld = 1'b1; step();
    run(12);
    for (int k = 0; k < 40 && m_cnt() != 3; k++) step();
    pr_sh = 8'd4; dc_sh = {4{8'd1}};
    ld = 1'b1; step();
    run(14);

    // soft_rst mid-period
    for (int k = 0; k < 40 && m_cnt() != 3; k++) step();
    pr_sh = 8'd9; dc_sh = {4{8'd4}};
    ld = 1'b1; step();
    run(12);
    for (int k = 0; k < 40 && m_cnt() != 6; k++) step();
    soft_rst = 1'b1; step();
    run(6);

    // ld arriving in the very cycle of the boundary tick
    for (int k = 0; k < 40 && m_cnt() != m_pr; k++) step();
    pr_sh = 8'd6; dc_sh = {8'd7, 8'd2, 8'd0, 8'd5};
    ld = 1'b1; step();
    run(10);

    // on deassert with a new polarity, then restart
    pol = 4'b1010; on = 1'b0; run(3);
    on = 1'b1; run(8);

    // sys_rst mid-period
    sys_rst = 1'b1; step();
    sys_rst = 1'b0; run(3);

    // Random mix
    for (int k = 0; k < 600; k++) begin
      cnt_tick = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        ld    = 1'b1;
        pr_sh = 8'($urandom_range(0, 12));
        for (int i = 0; i < CH; i++) begin
          dc_sh[i*W +: W] = 8'($urandom_range(0, 14));
          ph_sh[i*W +: W] = 8'($urandom_range(0, 20));
        end
      end
      if ($urandom_range(0, 29) == 0) pol = 4'($urandom);
      if ($urandom_range(0, 29) == 0) oen = 4'($urandom);
      if ($urandom_range(0, 39) == 0) center = ~center;
      if ($urandom_range(0, 59) == 0) soft_rst = 1'b1;
      if ($urandom_range(0, 79) == 0) on = ~on;
      if (k == 300) on = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
